// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared opcodes, ALU_OP encodings, FSM states and XZR index
package legv8_pkg;

    // Opcode prefixes. B and CBZ are matched on their short prefixes.
    // The remaining instructions are matched on the full 11-bit field.
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_BR = 1'b1
    } state_t;

endpackage

// File: rtl/legv8_instr_decoder.sv
// rtl/legv8_instr_decoder.sv - combinational LEGv8 decode of one instruction word
//
// Ports:
//   instruction   in   32-bit instruction word
//   reg2loc .. uncon_branch, alu_op   out  control bits
//   opcode        out  instruction[31:21]
//   read_reg_1/2, write_reg           out  register addresses
//   imm           out  sign-extended immediate, ADDR_W bits (ADDR_W > 28)
//   illegal       out  word matches no supported opcode
module legv8_instr_decoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [31:0]       instruction,
    output logic              reg2loc,
    output logic              regwrite,
    output logic              memread,
    output logic              memwrite,
    output logic              mem2reg,
    output logic              alusrc,
    output logic              branch,
    output logic              uncon_branch,
    output logic [1:0]        alu_op,
    output logic [10:0]       opcode,
    output logic [4:0]        read_reg_1,
    output logic [4:0]        read_reg_2,
    output logic [4:0]        write_reg,
    output logic [ADDR_W-1:0] imm,
    output logic              illegal
);

    always_comb begin
        reg2loc      = 1'b0;
        regwrite     = 1'b0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        mem2reg      = 1'b0;
        alusrc       = 1'b0;
        branch       = 1'b0;
        uncon_branch = 1'b0;
        alu_op       = ALUOP_MEM;
        imm          = '0;
        illegal      = 1'b0;
        if (instruction[31:26] == OP_B) begin
            uncon_branch = 1'b1;
            alu_op       = ALUOP_BR;
            imm          = {{(ADDR_W-28){instruction[25]}}, instruction[25:0], 2'b00};
        end else if (instruction[31:24] == OP_CBZ) begin
            branch  = 1'b1;
            reg2loc = 1'b1;
            alu_op  = ALUOP_BR;
            imm     = {{(ADDR_W-21){instruction[23]}}, instruction[23:5], 2'b00};
        end else begin
            case (instruction[31:21])
                OP_LDUR: begin
                    memread  = 1'b1;
                    mem2reg  = 1'b1;
                    regwrite = 1'b1;
                    alusrc   = 1'b1;
                    imm      = {{(ADDR_W-9){instruction[20]}}, instruction[20:12]};
                end
                OP_STUR: begin
                    memwrite = 1'b1;
                    mem2reg  = 1'b1;
                    alusrc   = 1'b1;
                    reg2loc  = 1'b1;
                    imm      = {{(ADDR_W-9){instruction[20]}}, instruction[20:12]};
                end
                OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                    regwrite = 1'b1;
                    alu_op   = ALUOP_R;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign opcode     = instruction[31:21];
    assign read_reg_1 = instruction[9:5];
    assign read_reg_2 = reg2loc ? instruction[4:0] : instruction[20:16];
    assign write_reg  = instruction[4:0];

endmodule

// File: rtl/legv8_ctrl_pipe.sv
// rtl/legv8_ctrl_pipe.sv - pipelined LEGv8 control: fetch PC, decode register, branch and load-use handling
//
// Ports:
//   CLOCK, RESET_N                     clock, async active-low reset
//   INSTRUCTION, INSTR_VALID/READY     fetch-side handshake
//   PC                                 fetch address
//   DEC_VALID/READY + bundle outputs   registered decode bundle towards execute
//   BR_VALID, BR_TAKEN                 CBZ outcome from execute
//   FLUSH, FLUSH_PC                    redirect request
//   ILLEGAL                            sticky unknown-opcode flag
module legv8_ctrl_pipe
    import legv8_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] PC_RESET   = '0,
    parameter int                LOAD_STALL = 1,
    parameter int                STALL_W    = 2
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [31:0]       INSTRUCTION,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    output logic [ADDR_W-1:0] PC,
    output logic              DEC_VALID,
    input  logic              DEC_READY,
    output logic              REG2LOC,
    output logic              REGWRITE,
    output logic              MEMREAD,
    output logic              MEMWRITE,
    output logic              MEM2REG,
    output logic              ALUSRC,
    output logic              BRANCH,
    output logic              UNCON_BRANCH,
    output logic [1:0]        ALU_OP,
    output logic [10:0]       OPCODE,
    output logic [4:0]        READ_REG_1,
    output logic [4:0]        READ_REG_2,
    output logic [4:0]        WRITE_REG,
    output logic [ADDR_W-1:0] IMM,
    input  logic              BR_VALID,
    input  logic              BR_TAKEN,
    input  logic              FLUSH,
    input  logic [ADDR_W-1:0] FLUSH_PC,
    output logic              ILLEGAL
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic              d_reg2loc, d_regwrite, d_memread, d_memwrite;
    logic              d_mem2reg, d_alusrc, d_branch, d_uncon_branch, d_illegal;
    logic [1:0]        d_alu_op;
    logic [10:0]       d_opcode;
    logic [4:0]        d_read_reg_1, d_read_reg_2, d_write_reg;
    logic [ADDR_W-1:0] d_imm;

    state_t             state, state_nxt;
    logic [STALL_W-1:0] stall_cnt;
    logic [4:0]         last_ld;
    logic [ADDR_W-1:0]  br_target, br_fall;
    logic               hazard, accept;

    legv8_instr_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .instruction (INSTRUCTION),
        .reg2loc     (d_reg2loc),
        .regwrite    (d_regwrite),
        .memread     (d_memread),
        .memwrite    (d_memwrite),
        .mem2reg     (d_mem2reg),
        .alusrc      (d_alusrc),
        .branch      (d_branch),
        .uncon_branch(d_uncon_branch),
        .alu_op      (d_alu_op),
        .opcode      (d_opcode),
        .read_reg_1  (d_read_reg_1),
        .read_reg_2  (d_read_reg_2),
        .write_reg   (d_write_reg),
        .imm         (d_imm),
        .illegal     (d_illegal)
    );

    // XZR never carries a loaded value, so a load into it never blocks a reader.
    assign hazard = (stall_cnt != '0) && (last_ld != XZR) &&
                    ((d_read_reg_1 == last_ld) || (d_read_reg_2 == last_ld));

    assign INSTR_READY = RESET_N && (state == RUN) && !FLUSH &&
                         (!DEC_VALID || DEC_READY) && !hazard;
    assign accept      = INSTR_VALID && INSTR_READY;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept && d_branch) state_nxt = WAIT_BR;
            WAIT_BR: if (FLUSH || BR_VALID)  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Load-use tracker: armed when a load leaves the decode register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt <= '0;
            last_ld   <= '0;
        end else if (FLUSH) begin
            stall_cnt <= '0;
        end else if (DEC_VALID && DEC_READY && MEMREAD) begin
            stall_cnt <= STALL_W'(LOAD_STALL);
            last_ld   <= WRITE_REG;
        end else if (stall_cnt != '0) begin
            stall_cnt <= stall_cnt - STALL_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            PC           <= PC_RESET;
            DEC_VALID    <= 1'b0;
            REG2LOC      <= 1'b0;
            REGWRITE     <= 1'b0;
            MEMREAD      <= 1'b0;
            MEMWRITE     <= 1'b0;
            MEM2REG      <= 1'b0;
            ALUSRC       <= 1'b0;
            BRANCH       <= 1'b0;
            UNCON_BRANCH <= 1'b0;
            ALU_OP       <= '0;
            OPCODE       <= '0;
            READ_REG_1   <= '0;
            READ_REG_2   <= '0;
            WRITE_REG    <= '0;
            IMM          <= '0;
            ILLEGAL      <= 1'b0;
            br_target    <= '0;
            br_fall      <= '0;
        end else if (FLUSH) begin
            PC        <= FLUSH_PC;
            DEC_VALID <= 1'b0;
        end else if (state == WAIT_BR && BR_VALID) begin
            PC <= BR_TAKEN ? br_target : br_fall;
            if (DEC_READY) DEC_VALID <= 1'b0;
        end else if (accept) begin
            if (d_illegal) begin
                // Unknown words are swallowed; any held bundle was consumed this cycle.
                ILLEGAL   <= 1'b1;
                DEC_VALID <= 1'b0;
                PC        <= PC + PC_STEP;
            end else begin
                DEC_VALID    <= 1'b1;
                REG2LOC      <= d_reg2loc;
                REGWRITE     <= d_regwrite;
                MEMREAD      <= d_memread;
                MEMWRITE     <= d_memwrite;
                MEM2REG      <= d_mem2reg;
                ALUSRC       <= d_alusrc;
                BRANCH       <= d_branch;
                UNCON_BRANCH <= d_uncon_branch;
                ALU_OP       <= d_alu_op;
                OPCODE       <= d_opcode;
                READ_REG_1   <= d_read_reg_1;
                READ_REG_2   <= d_read_reg_2;
                WRITE_REG    <= d_write_reg;
                IMM          <= d_imm;
                if (d_uncon_branch) begin
                    PC <= PC + d_imm;
                end else if (d_branch) begin
                    // PC stays put until execute resolves the condition.
                    br_target <= PC + d_imm;
                    br_fall   <= PC + PC_STEP;
                end else begin
                    PC <= PC + PC_STEP;
                end
            end
        end else if (DEC_READY) begin
            DEC_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_legv8_ctrl_pipe.sv
// tb/tb_legv8_ctrl_pipe.sv - self-checking bench for legv8_ctrl_pipe
module tb_legv8_ctrl_pipe;

    localparam int LOAD_STALL = 1;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID, INSTR_READY;
    logic [63:0] PC;
    logic        DEC_VALID, DEC_READY;
    logic        REG2LOC, REGWRITE, MEMREAD, MEMWRITE, MEM2REG, ALUSRC, BRANCH, UNCON_BRANCH;
    logic [1:0]  ALU_OP;
    logic [10:0] OPCODE;
    logic [4:0]  READ_REG_1, READ_REG_2, WRITE_REG;
    logic [63:0] IMM;
    logic        BR_VALID, BR_TAKEN, FLUSH;
    logic [63:0] FLUSH_PC;
    logic        ILLEGAL;

    int checks = 0;
    int errors = 0;

    legv8_ctrl_pipe #(.ADDR_W(64), .PC_RESET(64'h0), .LOAD_STALL(LOAD_STALL), .STALL_W(2)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .PC(PC), .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY),
        .REG2LOC(REG2LOC), .REGWRITE(REGWRITE), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
        .MEM2REG(MEM2REG), .ALUSRC(ALUSRC), .BRANCH(BRANCH), .UNCON_BRANCH(UNCON_BRANCH),
        .ALU_OP(ALU_OP), .OPCODE(OPCODE), .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
        .WRITE_REG(WRITE_REG), .IMM(IMM), .BR_VALID(BR_VALID), .BR_TAKEN(BR_TAKEN),
        .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC), .ILLEGAL(ILLEGAL)
    );

    always #5 CLOCK = ~CLOCK;

    localparam logic [10:0] M_LDUR = 11'b11111000010;
    localparam logic [10:0] M_STUR = 11'b11111000000;
    localparam logic [10:0] M_ADD  = 11'b10001011000;
    localparam logic [10:0] M_SUB  = 11'b11001011000;
    localparam logic [10:0] M_AND  = 11'b10001010000;
    localparam logic [10:0] M_ORR  = 11'b10101010000;

    typedef struct packed {
        logic        reg2loc, regwrite, memread, memwrite, mem2reg, alusrc, branch, uncon;
        logic [1:0]  aluop;
        logic [10:0] opcode;
        logic [4:0]  rr1, rr2, wr;
        logic [63:0] imm;
    } dec_t;

    function automatic logic [31:0] enc_r(logic [10:0] op, int rd, int rn, int rm);
        return {op, 5'(rm), 6'b0, 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] enc_mem(logic [10:0] op, int rt, int rn, int off);
        return {op, 9'(off), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] enc_b(int off);
        return {6'b000101, 26'(off)};
    endfunction
    function automatic logic [31:0] enc_cbz(int rt, int off);
        return {8'b10110100, 19'(off), 5'(rt)};
    endfunction

    // Reference decode from the instruction table; immediates via signed arithmetic.
    function automatic dec_t ref_decode(logic [31:0] w);
        dec_t   d;
        longint v;
        d = '0;
        d.opcode = w[31:21];
        if (w[31:26] == 6'b000101) begin
            d.uncon = 1; d.aluop = 2'd1;
            v = longint'(w[25:0]);
            if (w[25]) v = v - (longint'(1) <<< 26);
            d.imm = v * 4;
        end else if (w[31:24] == 8'b10110100) begin
            d.branch = 1; d.reg2loc = 1; d.aluop = 2'd1;
            v = longint'(w[23:5]);
            if (w[23]) v = v - (longint'(1) <<< 19);
            d.imm = v * 4;
        end else if (w[31:21] == M_LDUR || w[31:21] == M_STUR) begin
            d.memread = (w[31:21] == M_LDUR);
            d.regwrite = d.memread;
            d.memwrite = !d.memread;
            d.reg2loc = !d.memread;
            d.mem2reg = 1; d.alusrc = 1; d.aluop = 2'd0;
            v = longint'(w[20:12]);
            if (w[20]) v = v - 512;
            d.imm = v;
        end else begin
            d.regwrite = 1; d.aluop = 2'd2;
        end
        d.rr1 = w[9:5];
        d.rr2 = d.reg2loc ? w[4:0] : w[20:16];
        d.wr  = w[4:0];
        return d;
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic redirect(logic [63:0] target);
        FLUSH = 1; FLUSH_PC = target; INSTR_VALID = 0;
        tick();
        FLUSH = 0;
    endtask

    task automatic test_reset();
        RESET_N = 0;
        tick(); tick();
        checks++; if (PC !== 64'h0) begin errors++; $display("FAIL reset_pc: got %0h want 0", PC); end
        checks++; if (DEC_VALID !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b want 0", DEC_VALID); end
        checks++; if ({REGWRITE, MEMREAD, BRANCH, UNCON_BRANCH, ILLEGAL} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {REGWRITE, MEMREAD, BRANCH, UNCON_BRANCH, ILLEGAL}); end
        checks++; if (IMM !== 64'h0) begin errors++; $display("FAIL reset_imm: got %0h want 0", IMM); end
        checks++; if (INSTR_READY !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", INSTR_READY); end
        RESET_N = 1;
        #1;
        checks++; if (INSTR_READY !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", INSTR_READY); end
    endtask

    task automatic test_add_hold();
        INSTRUCTION = enc_r(M_ADD, 1, 2, 3); INSTR_VALID = 1; DEC_READY = 0;
        tick();
        INSTRUCTION = enc_r(M_SUB, 9, 9, 9);
        checks++; if (DEC_VALID !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", DEC_VALID); end
        checks++; if (REGWRITE !== 1'b1 || ALU_OP !== 2'b10) begin errors++; $display("FAIL add_ctrl: got %b/%b want 1/10", REGWRITE, ALU_OP); end
        checks++; if (READ_REG_1 !== 5'd2 || READ_REG_2 !== 5'd3 || WRITE_REG !== 5'd1)
            begin errors++; $display("FAIL add_regs: got %0d/%0d/%0d want 2/3/1", READ_REG_1, READ_REG_2, WRITE_REG); end
        checks++; if (PC !== 64'h4) begin errors++; $display("FAIL add_pc: got %0h want 4", PC); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (INSTR_READY !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", INSTR_READY); end
            tick();
            checks++; if (DEC_VALID !== 1'b1 || PC !== 64'h4 || WRITE_REG !== 5'd1 || OPCODE !== M_ADD)
                begin errors++; $display("FAIL hold_stable: got v=%b pc=%0h wr=%0d op=%h want 1/4/1/%h", DEC_VALID, PC, WRITE_REG, OPCODE, M_ADD); end
        end
        INSTR_VALID = 0; DEC_READY = 1;
        tick();
        checks++; if (DEC_VALID !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", DEC_VALID); end
    endtask

    task automatic test_branch_b(logic [63:0] at, logic [63:0] want_pc);
        redirect(at);
        INSTRUCTION = enc_b(-2); INSTR_VALID = 1; DEC_READY = 1;
        tick();
        INSTR_VALID = 0;
        checks++; if (PC !== want_pc) begin errors++; $display("FAIL b_pc: got %0h want %0h", PC, want_pc); end
        checks++; if (UNCON_BRANCH !== 1'b1 || ALU_OP !== 2'b01 || REGWRITE !== 1'b0 || MEMWRITE !== 1'b0 || DEC_VALID !== 1'b1)
            begin errors++; $display("FAIL b_ctrl: got u=%b op=%b rw=%b mw=%b v=%b", UNCON_BRANCH, ALU_OP, REGWRITE, MEMWRITE, DEC_VALID); end
        checks++; if (IMM !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL b_imm: got %0h want fffffffffffffff8", IMM); end
        tick();
    endtask

    task automatic test_cbz(logic taken);
        logic [63:0] want;
        want = taken ? 64'h30 : 64'h24;
        redirect(64'h20);
        INSTRUCTION = enc_cbz(4, 4); INSTR_VALID = 1; DEC_READY = 1;
        tick();
        checks++; if (PC !== 64'h20 || DEC_VALID !== 1'b1 || BRANCH !== 1'b1 || REG2LOC !== 1'b1 || ALU_OP !== 2'b01)
            begin errors++; $display("FAIL cbz_issue: got pc=%0h v=%b br=%b r2l=%b op=%b", PC, DEC_VALID, BRANCH, REG2LOC, ALU_OP); end
        checks++; if (READ_REG_2 !== 5'd4 || IMM !== 64'h10) begin errors++; $display("FAIL cbz_fields: got rr2=%0d imm=%0h want 4/10", READ_REG_2, IMM); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (INSTR_READY !== 1'b0 || PC !== 64'h20) begin errors++; $display("FAIL cbz_wait: got rdy=%b pc=%0h want 0/20", INSTR_READY, PC); end
            tick();
        end
        INSTR_VALID = 0; BR_VALID = 1; BR_TAKEN = taken;
        tick();
        BR_VALID = 0;
        checks++; if (PC !== want) begin errors++; $display("FAIL cbz_resolve: got %0h want %0h", PC, want); end
        checks++; if (INSTR_READY !== 1'b1) begin errors++; $display("FAIL cbz_run: got %b want 1", INSTR_READY); end
        BR_VALID = 1; BR_TAKEN = 1;
        tick();
        BR_VALID = 0;
        checks++; if (PC !== want) begin errors++; $display("FAIL br_valid_in_run: got %0h want %0h", PC, want); end
    endtask

    task automatic test_stur();
        redirect(64'h60);
        INSTRUCTION = enc_mem(M_STUR, 9, 2, -1); INSTR_VALID = 1; DEC_READY = 1;
        tick();
        INSTR_VALID = 0;
        checks++; if ({MEMWRITE, REGWRITE, REG2LOC, ALUSRC, MEMREAD} !== 5'b10110 || READ_REG_2 !== 5'd9 || IMM !== 64'hFFFF_FFFF_FFFF_FFFF)
            begin errors++; $display("FAIL stur: got ctl=%b rr2=%0d imm=%0h want 10110/9/ffffffffffffffff", {MEMWRITE, REGWRITE, REG2LOC, ALUSRC, MEMREAD}, READ_REG_2, IMM); end
        tick();
    endtask

    task automatic test_load_use(int ld, int want_stall);
        int n;
        redirect(64'h40);
        INSTRUCTION = enc_mem(M_LDUR, ld, 1, 8); INSTR_VALID = 1; DEC_READY = 1;
        tick();
        INSTR_VALID = 0;
        checks++; if (MEMREAD !== 1'b1 || MEM2REG !== 1'b1 || WRITE_REG !== 5'(ld) || IMM !== 64'h8 || DEC_VALID !== 1'b1)
            begin errors++; $display("FAIL ldur_issue: got rd=%b wr=%0d imm=%0h v=%b", MEMREAD, WRITE_REG, IMM, DEC_VALID); end
        tick();
        INSTRUCTION = enc_r(M_ADD, 6, ld, 7); INSTR_VALID = 1;
        #1;
        n = 0;
        while (!INSTR_READY && n < 5) begin
            tick();
            n++;
        end
        checks++; if (n != want_stall) begin errors++; $display("FAIL load_use_stall: got %0d cycles want %0d", n, want_stall); end
        tick();
        INSTR_VALID = 0;
        checks++; if (DEC_VALID !== 1'b1 || WRITE_REG !== 5'd6 || READ_REG_1 !== 5'(ld) || PC !== 64'h48)
            begin errors++; $display("FAIL load_use_accept: got v=%b wr=%0d rr1=%0d pc=%0h", DEC_VALID, WRITE_REG, READ_REG_1, PC); end
        tick();
    endtask

    task automatic test_illegal();
        redirect(64'h80);
        INSTRUCTION = 32'hFFFF_FFFF; INSTR_VALID = 1; DEC_READY = 1;
        tick();
        INSTR_VALID = 0;
        checks++; if (ILLEGAL !== 1'b1 || DEC_VALID !== 1'b0 || PC !== 64'h84)
            begin errors++; $display("FAIL illegal: got ill=%b v=%b pc=%0h want 1/0/84", ILLEGAL, DEC_VALID, PC); end
        INSTRUCTION = enc_r(M_ORR, 1, 2, 3); INSTR_VALID = 1;
        tick();
        INSTR_VALID = 0;
        checks++; if (ILLEGAL !== 1'b1 || DEC_VALID !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got ill=%b v=%b want 1/1", ILLEGAL, DEC_VALID); end
        tick();
    endtask

    task automatic test_flush_reset();
        redirect(64'h20);
        INSTRUCTION = enc_cbz(2, 4); INSTR_VALID = 1; DEC_READY = 1;
        tick();
        INSTR_VALID = 0; DEC_READY = 0;
        FLUSH = 1; FLUSH_PC = 64'h100; BR_VALID = 1; BR_TAKEN = 1;
        tick();
        FLUSH = 0; BR_VALID = 0; DEC_READY = 1;
        #1;
        checks++; if (PC !== 64'h100 || DEC_VALID !== 1'b0 || INSTR_READY !== 1'b1)
            begin errors++; $display("FAIL flush_over_br: got pc=%0h v=%b rdy=%b want 100/0/1", PC, DEC_VALID, INSTR_READY); end
        INSTRUCTION = enc_cbz(2, 4); INSTR_VALID = 1;
        tick();
        INSTR_VALID = 0;
        checks++; if (INSTR_READY !== 1'b0 || PC !== 64'h100) begin errors++; $display("FAIL flush_cbz_wait: got rdy=%b pc=%0h", INSTR_READY, PC); end
        #3;
        RESET_N = 0;
        #1;
        checks++; if (PC !== 64'h0 || DEC_VALID !== 1'b0 || BRANCH !== 1'b0)
            begin errors++; $display("FAIL async_reset: got pc=%0h v=%b br=%b want 0/0/0", PC, DEC_VALID, BRANCH); end
        tick();
        RESET_N = 1;
        #1;
        checks++; if (INSTR_READY !== 1'b1) begin errors++; $display("FAIL reset_to_run: got %b want 1", INSTR_READY); end
        BR_VALID = 1; BR_TAKEN = 1;
        tick();
        BR_VALID = 0;
        checks++; if (PC !== 64'h0) begin errors++; $display("FAIL reset_discard_target: got %0h want 0", PC); end
    endtask

    function automatic int rnd_reg();
        return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 5));
    endfunction

    // Straight-line random program with random fetch/execute handshakes.
    task automatic test_random();
        logic [31:0] prog [256];
        logic [63:0] m_pc;
        logic        m_valid, exp_ready, acc, hs;
        logic [31:0] m_word;
        int          m_cnt;
        int          m_ld;
        dec_t        in_d, exp_d, obs_d;
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 5))
                0: prog[i] = enc_mem(M_LDUR, rnd_reg(), rnd_reg(), int'($urandom_range(0, 511)));
                1: prog[i] = enc_mem(M_STUR, rnd_reg(), rnd_reg(), int'($urandom_range(0, 511)));
                2: prog[i] = enc_r(M_ADD, rnd_reg(), rnd_reg(), rnd_reg());
                3: prog[i] = enc_r(M_SUB, rnd_reg(), rnd_reg(), rnd_reg());
                4: prog[i] = enc_r(M_AND, rnd_reg(), rnd_reg(), rnd_reg());
                default: prog[i] = enc_r(M_ORR, rnd_reg(), rnd_reg(), rnd_reg());
            endcase
        end
        RESET_N = 0; INSTR_VALID = 0;
        tick();
        RESET_N = 1;
        m_pc = 0; m_valid = 0; m_word = 0; m_cnt = 0; m_ld = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            INSTR_VALID = ($urandom_range(0, 3) != 0);
            DEC_READY   = ($urandom_range(0, 2) != 0);
            INSTRUCTION = prog[m_pc[9:2]];
            #1;
            in_d = ref_decode(INSTRUCTION);
            exp_ready = !(m_valid && !DEC_READY) &&
                        !(m_cnt > 0 && m_ld != 31 && (int'(in_d.rr1) == m_ld || int'(in_d.rr2) == m_ld));
            checks++; if (INSTR_READY !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, INSTR_READY, exp_ready); end
            checks++; if (PC !== m_pc || DEC_VALID !== m_valid)
                begin errors++; $display("FAIL rnd_pc_valid c%0d: got %0h/%b want %0h/%b", cyc, PC, DEC_VALID, m_pc, m_valid); end
            exp_d = ref_decode(m_word);
            if (m_valid) begin
                obs_d = {REG2LOC, REGWRITE, MEMREAD, MEMWRITE, MEM2REG, ALUSRC, BRANCH, UNCON_BRANCH,
                         ALU_OP, OPCODE, READ_REG_1, READ_REG_2, WRITE_REG, IMM};
                checks++; if (obs_d !== exp_d) begin errors++; $display("FAIL rnd_bundle c%0d: got %h want %h", cyc, obs_d, exp_d); end
            end
            hs  = m_valid && DEC_READY;
            acc = INSTR_VALID && exp_ready;
            if (hs && exp_d.memread) begin
                m_cnt = LOAD_STALL; m_ld = int'(exp_d.wr);
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
            if (acc) begin
                m_valid = 1; m_word = INSTRUCTION; m_pc = m_pc + 4;
            end else if (hs) begin
                m_valid = 0;
            end
            tick();
        end
        checks++; if (ILLEGAL !== 1'b0) begin errors++; $display("FAIL rnd_illegal: got %b want 0", ILLEGAL); end
        INSTR_VALID = 0; DEC_READY = 1;
        tick();
    endtask

    initial begin
        RESET_N = 0; INSTRUCTION = 0; INSTR_VALID = 0; DEC_READY = 0;
        BR_VALID = 0; BR_TAKEN = 0; FLUSH = 0; FLUSH_PC = 0;
        test_reset();
        test_add_hold();
        test_branch_b(64'h10, 64'h08);
        test_branch_b(64'h0, 64'hFFFF_FFFF_FFFF_FFF8);
        test_cbz(1'b1);
        test_cbz(1'b0);
        test_stur();
        test_load_use(5, LOAD_STALL);
        test_load_use(31, 0);
        test_illegal();
        test_random();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
